// File: rtl/dcf77_if.sv
// dcf77_if: bundles the decoder's tick/input pair and its decoded-bit outputs.
//   master : the decoder (takes clk_en/dcf_in, drives the result signals)
//   slave  : whoever supplies the tick and the receiver signal and consumes results
// Signals:
//   clk_en        10 ms tick, one clk wide
//   dcf_in        raw receiver output, asynchronous, 1 = carrier reduced
//   bit_valid     one-clk strobe, new data bit
//   bit_value     decoded bit, held until next bit_valid
//   bit_index     second index 0..58 of that bit
//   minute_start  one-clk strobe at the minute-marker rising edge
//   synced        level, marker seen and no error since
//   err           one-clk strobe on any timing violation
interface dcf77_if;
   logic       clk_en;
   logic       dcf_in;
   logic       bit_valid;
   logic       bit_value;
   logic [5:0] bit_index;
   logic       minute_start;
   logic       synced;
   logic       err;

   modport master (
      input  clk_en, dcf_in,
      output bit_valid, bit_value, bit_index, minute_start, synced, err
   );

   modport slave (
      output clk_en, dcf_in,
      input  bit_valid, bit_value, bit_index, minute_start, synced, err
   );
endinterface

// File: rtl/dcf77_pulse_decoder.sv
// dcf77_pulse_decoder: classifies DCF77 carrier-reduction pulses into data bits,
// finds the minute marker (missing second 59), tracks the second index and
// strobes err on any timing violation. All state advances only on clk_en ticks.
// Ports:
//   clk  system clock
//   rst  synchronous, active-high reset
//   bus  dcf77_if.master (clk_en, dcf_in in; bit_valid, bit_value, bit_index,
//        minute_start, synced, err out)
// Build option:
//   DCF77_GLITCH_FILTER_EN  when defined, the tick-sampled level is a 3-sample
//                           majority vote (rejects single-tick glitches, adds
//                           2 ticks of latency to both edges).
module dcf77_pulse_decoder (
   input  logic     clk,
   input  logic     rst,
   dcf77_if.master  bus
);

   // S_NOREF: no reference rising edge yet; S_HUNT: reference held, not synced;
   // S_SYNC: minute marker seen and no error since.
   typedef enum logic [1:0] {S_NOREF, S_HUNT, S_SYNC} state_t;

   state_t     state_q, state_d;
   logic       sync1_q, sync2_q;
   logic       lvl_q;            // L at the previous tick
   logic       lvl_now;          // L at the current tick
   logic [4:0] width_q;
   logic [7:0] period_q;
   logic [5:0] sec_q, sec_d;
   logic [4:0] w_eval;
   logic [7:0] p_eval;
   logic       rise, fall, timeout;
   logic       w_zero, w_one, p_marker, p_second;
   logic       err_d, mark_d, bit_d;

   // two-flop synchronizer, free running on clk
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= bus.dcf_in;
         sync2_q <= sync1_q;
      end
   end

`ifdef DCF77_GLITCH_FILTER_EN
   logic [2:0] shift_q;

   always_ff @(posedge clk) begin
      if (rst)
         shift_q <= 3'b000;
      else if (bus.clk_en)
         shift_q <= {shift_q[1:0], sync2_q};
   end

   // vote over the registered history, so the level lags the input by 2 ticks
   assign lvl_now = (shift_q[0] & shift_q[1]) | (shift_q[0] & shift_q[2]) |
                    (shift_q[1] & shift_q[2]);
`else
   assign lvl_now = sync2_q;
`endif

   assign rise = bus.clk_en &  lvl_now & ~lvl_q;
   assign fall = bus.clk_en & ~lvl_now &  lvl_q;

   // W and P include the edge tick itself, i.e. they are ticks since the rising edge
   assign w_eval = (width_q  == 5'd31)  ? 5'd31  : width_q  + 5'd1;
   assign p_eval = (period_q == 8'd255) ? 8'd255 : period_q + 8'd1;

   assign w_zero   = (w_eval >= 5'd5)   && (w_eval <= 5'd14);
   assign w_one    = (w_eval >= 5'd15)  && (w_eval <= 5'd25);
   assign p_marker = (p_eval >= 8'd195) && (p_eval <= 8'd205);
   assign p_second = (p_eval >= 8'd95)  && (p_eval <= 8'd105);

   // fires once, on the tick where the period counter steps onto 255
   assign timeout = bus.clk_en & ~rise & (period_q == 8'd254);

   always_ff @(posedge clk) begin
      if (rst)
         state_q <= S_NOREF;
      else if (bus.clk_en)
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      sec_d   = sec_q;
      err_d   = 1'b0;
      mark_d  = 1'b0;
      bit_d   = 1'b0;

      if (rise) begin
         if (state_q == S_NOREF) begin
            state_d = S_HUNT;
         end else if (p_marker) begin
            sec_d   = 6'd0;
            state_d = S_SYNC;
            mark_d  = 1'b1;
         end else if (p_second && (sec_q != 6'd58)) begin
            sec_d = sec_q + 6'd1;
         end else begin
            // this edge stays as the reference for the next period
            err_d   = 1'b1;
            sec_d   = 6'd0;
            state_d = S_HUNT;
         end
      end else if (fall) begin
         if (w_zero || w_one) begin
            bit_d = (state_q == S_SYNC);
         end else begin
            err_d   = 1'b1;
            sec_d   = 6'd0;
            state_d = S_NOREF;
         end
      end

      if (timeout) begin
         err_d   = 1'b1;
         bit_d   = 1'b0;
         sec_d   = 6'd0;
         state_d = S_NOREF;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lvl_q            <= 1'b0;
         width_q          <= 5'd0;
         period_q         <= 8'd0;
         sec_q            <= 6'd0;
         bus.bit_valid    <= 1'b0;
         bus.bit_value    <= 1'b0;
         bus.bit_index    <= 6'd0;
         bus.minute_start <= 1'b0;
         bus.err          <= 1'b0;
      end else begin
         bus.bit_valid    <= 1'b0;
         bus.minute_start <= 1'b0;
         bus.err          <= 1'b0;
         if (bus.clk_en) begin
            lvl_q <= lvl_now;
            sec_q <= sec_d;

            if (rise)
               width_q <= 5'd0;
            else if (lvl_now && (width_q != 5'd31))
               width_q <= width_q + 5'd1;

            if (rise)
               period_q <= 8'd0;
            else if (period_q != 8'd255)
               period_q <= period_q + 8'd1;

            bus.bit_valid    <= bit_d;
            bus.minute_start <= mark_d;
            bus.err          <= err_d;
            if (bit_d) begin
               bus.bit_value <= w_one;
               bus.bit_index <= sec_q;
            end
         end
      end
   end

   assign bus.synced = (state_q == S_SYNC);

endmodule

// File: doc/dcf77_pulse_decoder.md
# dcf77_pulse_decoder

Samples the synchronized DCF77 demodulator output once per 10 ms clock-enable tick and classifies carrier-reduction pulses into data bits. Detects the minute marker (missing second 59), tracks the second index, and flags timing errors. Sits directly downstream of the 10 ms clock-enable generator and feeds the telegram assembler and parity checker.

## Interface
- No parameters; all thresholds are fixed tick counts at 10 ms per tick.
- clk  in  1  system clock, 24 MHz.
- rst  in  1  reset, synchronous, active-high.
- clk_en  in  1  10 ms tick, one clk wide, from the clock-enable generator.
- dcf_in  in  1  raw receiver output, asynchronous; 1 = carrier reduced (pulse).
- bit_valid  out  1  one-clk strobe: new data bit available.
- bit_value  out  1  decoded bit, held until the next bit_valid.
- bit_index  out  6  second index 0..58 of the bit, held with bit_value.
- minute_start  out  1  one-clk strobe at the minute-marker rising edge.
- synced  out  1  level: minute marker seen and no error since.
- err  out  1  one-clk strobe on any timing violation.

## Operation
- Input path: 2-flop synchronizer on clk, then sampled only on clk_en ticks, giving level L. L is optionally filtered (see Configuration).
- Edges are detected on ticks only, by comparing L with its value at the previous tick. All state updates occur only on clk_en ticks.
- width_cnt: 5 bit, saturates at 31. Cleared on the rising-edge tick and incremented on each later tick while L = 1. W = value at the falling-edge tick, in ticks since the rising edge.
- period_cnt: 8 bit, saturates at 255. Cleared on the rising-edge tick and incremented on every later tick. P = ticks between consecutive rising-edge ticks.
- Falling edge:
  - W in 5..14 gives bit 0; W in 15..25 gives bit 1; otherwise error.
  - If synced and no error: bit_valid = 1, bit_value = decoded bit, bit_index = sec_cnt.
- Rising edge, first one after reset or error (have_edge = 0): P is not evaluated; set have_edge.
- Rising edge with P in 195..205 (minute marker): sec_cnt = 0, synced = 1, minute_start = 1.
- Rising edge with P in 95..105 (normal second): sec_cnt + 1. Incrementing sec_cnt from 58 is an error.
- Any other P at a rising edge is an error.
- Timeout: period_cnt reaching 255 is an error (signal lost).
- Error: err = 1, synced = 0, sec_cnt = 0, have_edge = 0, except on a rising edge, where have_edge = 1 because that edge is the new reference. An error and a marker cannot coincide, since the P windows are disjoint.
- Unsynced operation: edges and counters keep running and errors still strobe err, but bit_valid is suppressed. The next valid marker resynchronizes.

## Timing
- Reset values: bit_valid 0, bit_value 0, bit_index 0, minute_start 0, synced 0, err 0; internal L 0, counters 0, have_edge 0.
- Outputs are registered at the clk edge where clk_en = 1 and are visible the following cycle. Strobes last exactly one clk.
- Latency from dcf_in to L: 2 clk of synchronizer, plus up to 1 tick to the next sample, plus 2 ticks when the filter is enabled.
- rst mid-pulse or mid-minute: everything returns to reset values on the same edge. The first rising edge afterwards is only a reference.
- clk_en is ignored while rst = 1.

## Configuration
- DCF77_GLITCH_FILTER_EN defined:
  - L = majority vote of the last 3 tick samples. A 3-bit shift register resets to 000.
  - Single-tick glitches are rejected. Adds 2 ticks of latency to both edges, so W and P are unchanged.
- Undefined: L = synchronized sample taken directly at each tick. A one-tick glitch produces W = 1, which is an error.

## Test plan
- Reset, then a 1 s pulse train of 100 ms width -> no bit_valid and synced = 0 until a 2 s gap. At the next rising edge: minute_start, synced = 1. After that pulse falls: bit_valid, bit_value 0, bit_index 0.
- Marker, then 58 seconds alternating 100/200 ms -> 59 strobes total, bit_index 0..58, values alternating 0/1. The following marker gives minute_start with no err.
- Synced, then a 300 ms pulse (W = 30) -> err strobe, synced = 0, no bit_valid for that pulse.
- Synced, then the carrier is held unreduced for 3 s -> err when period_cnt hits 255. The next two markers resync.
- Synced, then a pulse at P = 150 -> err, synced = 0. That edge becomes the reference, so a marker 200 ticks later resyncs.
- With DCF77_GLITCH_FILTER_EN: a single-tick spike in the gap -> no err, bits continue. Without the macro: err.
